parity_counter_bank: RTL and testbench

Multi-channel, parametrised successor to the single parity-gated counter used in our assertion-test designs. It holds CHANNELS independent WIDTH-bit counters. Each counter steps only when its input bit matches the parity of its own count, and can count up or down with wrap or saturate. The block exposes per-channel safety properties (`valid`), a global environment constraint (`assume`), and registered sticky failure bookkeeping, so it can serve as both a formal-checker target and a simulation self-check.

---
 rtl/parity_counter_bank.sv | 81 ++++++++
 tb/tb_parity_counter_bank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_counter_bank.sv
// Bank of independent parity-gated up/down counters with per-channel safety flags,
// a global environment constraint and sticky first-failure bookkeeping.
// The environment-constraint output is named assume_ok because "assume" is a reserved word.
module parity_counter_bank #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CIDX_W    = 2,
  parameter int unsigned BAD_VALUE = 25,
  parameter int unsigned LIMIT     = 50,
  parameter int unsigned SATURATE  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       x,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS-1:0]       clr,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       valid,
  output logic                      assume_ok,
  output logic                      fail,
  output logic [CIDX_W-1:0]         fail_chan,
  output logic [7:0]                viol_cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0] below_limit;
  logic                viol;
  logic [CIDX_W-1:0]   first_bad;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [WIDTH-1:0] cnt;
    logic             ena;

    assign ena = (x[i] == ^cnt);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (clr[i]) begin
        cnt <= '0;
      end else if (ena) begin
        if (!dir[i]) begin
          if (!(SATURATE != 0 && cnt == CNT_MAX)) cnt <= cnt + 1'b1;
        end else begin
          if (!(SATURATE != 0 && cnt == '0)) cnt <= cnt - 1'b1;
        end
      end
    end

    // Compares are done at 32 bits so out-of-range BAD_VALUE/LIMIT never alias.
    assign count[i*WIDTH +: WIDTH] = cnt;
    assign valid[i]                = (32'(cnt) != BAD_VALUE);
    assign below_limit[i]          = (32'(cnt) < LIMIT);
  end

  assign assume_ok = &below_limit;
  assign viol      = assume_ok & ~&valid;

  always_comb begin
    first_bad = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (!valid[i]) first_bad = CIDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail      <= 1'b0;
      fail_chan <= '0;
      viol_cnt  <= '0;
    end else if (viol) begin
      if (!fail) begin
        fail      <= 1'b1;
        fail_chan <= first_bad;
      end
      if (viol_cnt != 8'hFF) viol_cnt <= viol_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_parity_counter_bank.sv
// Directed and randomized checks of parity_counter_bank against an integer reference model,
// plus two 4-bit instances exercising wrap and saturate behaviour.
module tb_parity_counter_bank;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   x, dir, clr;
  logic [N*W-1:0] count;
  logic [N-1:0]   valid;
  logic           assume_ok, fail;
  logic [1:0]     fail_chan;
  logic [7:0]     viol_cnt;

  parity_counter_bank dut (
    .clk(clk), .rst(rst), .x(x), .dir(dir), .clr(clr), .count(count), .valid(valid),
    .assume_ok(assume_ok), .fail(fail), .fail_chan(fail_chan), .viol_cnt(viol_cnt)
  );

  logic [3:0]  wx, sx, sdir, sclr;
  logic [15:0] wcount, scount;
  logic [3:0]  wvalid, svalid;
  logic        wassume, sassume, wfail, sfail;
  logic [1:0]  wfc, sfc;
  logic [7:0]  wvc, svc;

  parity_counter_bank #(.WIDTH(4), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .x(wx), .dir(sdir), .clr(sclr), .count(wcount), .valid(wvalid),
    .assume_ok(wassume), .fail(wfail), .fail_chan(wfc), .viol_cnt(wvc)
  );

  parity_counter_bank #(.WIDTH(4), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .x(sx), .dir(sdir), .clr(sclr), .count(scount), .valid(svalid),
    .assume_ok(sassume), .fail(sfail), .fail_chan(sfc), .viol_cnt(svc)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: plain integer counts and bookkeeping.
  int m_cnt[N];
  bit m_fail;
  int m_chan;
  int m_viol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit par(input int v);
    return ($countones(v) % 2) == 1;
  endfunction

  function automatic bit m_assume();
    for (int i = 0; i < N; i++) if (m_cnt[i] >= 50) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_first_bad();
    for (int i = 0; i < N; i++) if (m_cnt[i] == 25) return i;
    return -1;
  endfunction

  task automatic check_all();
    logic [N-1:0] ev;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("count%0d", i), 32'(count[i*W +: W]), m_cnt[i]);
      ev[i] = (m_cnt[i] != 25);
    end
    chk("valid", 32'(valid), 32'(ev));
    chk("assume", 32'(assume_ok), 32'(m_assume()));
    chk("fail", 32'(fail), 32'(m_fail));
    chk("fail_chan", 32'(fail_chan), m_chan);
    chk("viol_cnt", 32'(viol_cnt), m_viol);
  endtask

  task automatic step(input logic [N-1:0] en, input logic [N-1:0] d, input logic [N-1:0] c);
    int nxt[N];
    bit v;
    int fb;
    for (int i = 0; i < N; i++) begin
      x[i] = en[i] ? par(m_cnt[i]) : !par(m_cnt[i]);
      if (c[i])       nxt[i] = 0;
      else if (en[i]) nxt[i] = d[i] ? (m_cnt[i] + 255) % 256 : (m_cnt[i] + 1) % 256;
      else            nxt[i] = m_cnt[i];
    end
    dir = d;
    clr = c;
    fb = m_first_bad();
    v  = m_assume() && (fb >= 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) m_cnt[i] = nxt[i];
    if (v && !m_fail) begin
      m_fail = 1'b1;
      m_chan = fb;
    end
    if (v && m_viol < 255) m_viol++;
    check_all();
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_fail = 1'b0;
    m_chan = 0;
    m_viol = 0;
  endtask

  // Reset is asserted and checked between clock edges.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    x = '0; dir = '0; clr = '0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int wm, sm;
    rst = 1'b1;
    x = '0; dir = '0; clr = '0;
    wx = 4'b1111; sx = 4'b1111; sdir = '0; sclr = '0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Channel 0 climbs to the forbidden value and trips the failure flag.
    repeat (25) step(4'b0001, 4'b0000, 4'b0000);
    chk("t1_count0", 32'(count[0 +: W]), 25);
    chk("t1_valid0", 32'(valid[0]), 0);
    step(4'b0000, 4'b0000, 4'b0000);
    chk("t1_fail", 32'(fail), 1);
    chk("t1_fail_chan", 32'(fail_chan), 0);
    chk("t1_viol_cnt", 32'(viol_cnt), 1);

    // Clear wins over an enabled step.
    do_reset();
    repeat (7) step(4'b0001, 4'b0000, 4'b0000);
    chk("clr_pre", 32'(count[0 +: W]), 7);
    step(4'b0001, 4'b0000, 4'b0001);
    chk("clr_count0", 32'(count[0 +: W]), 0);

    // Channel 2 at 255 masks the violation on channel 3.
    do_reset();
    step(4'b0100, 4'b0100, 4'b0000);
    chk("mask_count2", 32'(count[2*W +: W]), 255);
    chk("mask_assume", 32'(assume_ok), 0);
    repeat (25) step(4'b1000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);
    chk("mask_count3", 32'(count[3*W +: W]), 25);
    chk("mask_fail", 32'(fail), 0);
    chk("mask_viol_cnt", 32'(viol_cnt), 0);

    // Channels 1 and 3 hit 25 together; lowest index is recorded.
    do_reset();
    repeat (25) step(4'b1010, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);
    chk("sim_fail", 32'(fail), 1);
    chk("sim_fail_chan", 32'(fail_chan), 1);

    repeat (300) step(4'b0000, 4'b0000, 4'b0000);
    chk("sat_viol_cnt", 32'(viol_cnt), 255);
    chk("sat_fail_chan", 32'(fail_chan), 1);

    // Mid-operation reset with fail set and non-zero counts.
    do_reset();
    chk("rst_viol_cnt", 32'(viol_cnt), 0);
    chk("rst_fail", 32'(fail), 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] c;
      c = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      step(N'($urandom), N'($urandom), c);
    end

    // 4-bit wrap and saturate on channel 1.
    wm = 0;
    sm = 0;
    for (int k = 1; k <= 20; k++) begin
      wx[1] = par(wm);
      sx[1] = par(sm);
      @(posedge clk);
      #1;
      wm = (wm + 1) % 16;
      sm = (sm < 15) ? sm + 1 : 15;
      chk($sformatf("wrap_e%0d", k), 32'(wcount[4 +: 4]), wm);
      chk($sformatf("satu_e%0d", k), 32'(scount[4 +: 4]), sm);
    end
    chk("wrap_ch0", 32'(wcount[0 +: 4]), 0);
    chk("satu_ch0", 32'(scount[0 +: 4]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
